// File: rtl/cam_pkg.sv
// Shared constants for the camera capture path: FSM encoding, RGB565 field layout, sync depth.
// Also holds the 5/6-bit to 8-bit colour expansion helpers.
package cam_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam int SYNC_DEPTH = 2;

    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

endpackage

// File: rtl/cam_sync.sv
// Multi-bit synchroniser (SYNC_DEPTH flops) plus one delayed copy for edge detection.
// Latency SYNC_DEPTH clk to sync_o, edges one flop later in effect; no backpressure.
module cam_sync
    import cam_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] pipe_q [SYNC_DEPTH+1];
    logic [WIDTH-1:0] pipe_d [SYNC_DEPTH+1];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i <= SYNC_DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= SYNC_DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign sync_o = pipe_q[SYNC_DEPTH-1];
    assign rise_o = pipe_q[SYNC_DEPTH-1] & ~pipe_q[SYNC_DEPTH];
    assign fall_o = ~pipe_q[SYNC_DEPTH-1] & pipe_q[SYNC_DEPTH];

endmodule

// File: rtl/cam_capture.sv
// Oversampled DVP camera capture: byte pairs -> RGB565 pixels with x/y, frame markers and error flags.
// pix_valid 3 clk after cam_pclk first sampled high; no backpressure, pixels are strobed out.
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X_BITS   = 12,
    parameter int Y_BITS   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_d,
    output logic              pix_valid,
    output logic [15:0]       pix_data,
    output logic [7:0]        r_out,
    output logic [7:0]        g_out,
    output logic [7:0]        b_out,
    output logic [X_BITS-1:0] pix_x,
    output logic [Y_BITS-1:0] pix_y,
    output logic              frame_start,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [X_BITS-1:0] H_MAX = X_BITS'(H_ACTIVE);
    localparam logic [Y_BITS-1:0] V_MAX = Y_BITS'(V_ACTIVE);

    // Bit layout: {pclk, vsync, href, d[7:0]}
    logic [10:0] sync_v, rise_v, fall_v;

    cam_sync #(.WIDTH(11)) u_sync (
        .clk    (clk),
        .rst_n  (reset),
        .din    ({cam_pclk, cam_vsync, cam_href, cam_d}),
        .sync_o (sync_v),
        .rise_o (rise_v),
        .fall_o (fall_v)
    );

    logic       pclk_rise, vsync_rise, vsync_fall, href_fall, href_s;
    logic [7:0] d_s;
    logic       unused_sync;

    assign pclk_rise   = rise_v[10];
    assign vsync_rise  = rise_v[9];
    assign vsync_fall  = fall_v[9];
    assign href_fall   = fall_v[8];
    assign href_s      = sync_v[8];
    assign d_s         = sync_v[7:0];
    assign unused_sync = ^{sync_v[10:9], rise_v[8:0], fall_v[10], fall_v[7:0]};

    state_t            state_q, state_d;
    logic [X_BITS-1:0] x_q, x_d, pix_x_q, pix_x_d;
    logic [Y_BITS-1:0] y_q, y_d, pix_y_q, pix_y_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = line_err_q;
        frame_err_d   = frame_err_q;

        case (state_q)
            S_IDLE: begin
                if (capture_en) state_d = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (vsync_fall) begin
                    state_d       = S_CAPTURE;
                    frame_start_d = 1'b1;
                    line_err_d    = 1'b0;
                    frame_err_d   = 1'b0;
                    x_d           = '0;
                    y_d           = '0;
                    phase_d       = 1'b0;
                end
            end
            S_CAPTURE: begin
                // Byte first, then line end, then frame end: later steps see the updated x/phase/y.
                if (pclk_rise && href_s) begin
                    if (!phase_q) begin
                        hi_d    = d_s;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (x_q < H_MAX && y_q < V_MAX) begin
                            pix_valid_d = 1'b1;
                            pix_data_d  = {hi_q, d_s};
                            pix_x_d     = x_q;
                            pix_y_d     = y_q;
                        end else if (x_q >= H_MAX) begin
                            line_err_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        if (x_q < H_MAX) x_d = x_q + 1'b1;
                    end
                end
                if (href_fall || (vsync_rise && href_s)) begin
                    if (x_d != H_MAX || phase_d) line_err_d = 1'b1;
                    x_d     = '0;
                    phase_d = 1'b0;
                    if (y_q < V_MAX) y_d = y_q + 1'b1;
                end
                if (vsync_rise) begin
                    if (y_d != V_MAX) frame_err_d = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = capture_en ? S_WAIT_VS : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign r_out       = expand5(pix_data_q[R_MSB:R_LSB]);
    assign g_out       = expand6(pix_data_q[G_MSB:G_LSB]);
    assign b_out       = expand5(pix_data_q[B_MSB:B_LSB]);
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture with a 4x2 frame: camera bytes driven by tasks, expected pixels queued
// in a scoreboard and compared by a monitor on the falling clk edge.
module tb_cam_capture;

    localparam int H_ACTIVE = 4;
    localparam int V_ACTIVE = 2;

    typedef struct {
        logic [15:0] d;
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        capture_en = 1'b0;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_d = 8'h00;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [7:0]  r_out, g_out, b_out;
    logic [11:0] pix_x, pix_y;
    logic        frame_start, frame_done, line_err, frame_err, busy;

    int   vectors = 0;
    int   miscompares = 0;
    int   pv_cnt = 0;
    int   fs_cnt = 0;
    int   fd_cnt = 0;
    exp_t exp_q[$];

    logic [7:0] pat [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};

    cam_capture #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .X_BITS(12), .Y_BITS(12)) dut (
        .clk(clk), .reset(reset), .capture_en(capture_en),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .frame_done(frame_done),
        .line_err(line_err), .frame_err(frame_err), .busy(busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_start) fs_cnt++;
        if (frame_done)  fd_cnt++;
        if (pix_valid) begin
            exp_t e;
            pv_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pix_unexpected: got data=%h x=%0d y=%0d, required no pixel", pix_data, pix_x, pix_y);
            end else begin
                e = exp_q.pop_front();
                if ({pix_data, pix_x, pix_y, r_out, g_out, b_out} !== {e.d, e.x, e.y, e.r, e.g, e.b}) begin
                    miscompares++;
                    $display("FAIL pix: got d=%h x=%0d y=%0d rgb=%h/%h/%h, required d=%h x=%0d y=%0d rgb=%h/%h/%h",
                             pix_data, pix_x, pix_y, r_out, g_out, b_out, e.d, e.x, e.y, e.r, e.g, e.b);
                end
            end
        end
    end

    task automatic push_exp(input int k, input int ln);
        exp_t e;
        e.d = {pat[2*(k%4)], pat[2*(k%4)+1]};
        e.x = 12'(k);
        e.y = 12'(ln);
        e.r = {e.d[15:11], e.d[15:13]};
        e.g = {e.d[10:5], e.d[10:9]};
        e.b = {e.d[4:0], e.d[4:2]};
        exp_q.push_back(e);
    endtask

    task automatic cam_clk(input logic href, input logic [7:0] d);
        cam_href = href;
        cam_d    = d;
        #50 cam_pclk = 1'b1;
        #50 cam_pclk = 1'b0;
    endtask

    task automatic vs(input logic v, input int n);
        cam_vsync = v;
        repeat (n) cam_clk(1'b0, 8'h00);
    endtask

    task automatic send_line(input int nbytes, input int ln, input bit en, input int drop_at, input bit close);
        for (int i = 0; i < nbytes; i++) begin
            if (i == drop_at) capture_en = 1'b0;
            if (en && (i % 2 == 1) && (i / 2 < H_ACTIVE) && (ln < V_ACTIVE)) push_exp(i / 2, ln);
            cam_clk(1'b1, pat[i % 8]);
        end
        if (close) repeat (3) cam_clk(1'b0, 8'h00);
    endtask

    task automatic test_reset();
        #5;
        repeat (3) cam_clk(1'b1, 8'hA5);
        vectors++;
        if ({pix_valid, pix_data, r_out, g_out, b_out, pix_x, pix_y, frame_start, frame_done,
             line_err, frame_err, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got pv=%b d=%h x=%0d y=%0d busy=%b le=%b fe=%b, required all 0",
                     pix_valid, pix_data, pix_x, pix_y, busy, line_err, frame_err);
        end
        reset = 1'b1;
        cam_href = 1'b0;
        vs(1'b1, 3);
        vs(1'b0, 3);
        send_line(8, 0, 1'b0, -1, 1'b1);
        vs(1'b1, 3);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_busy: got %b, required 0", busy);
        end
        vectors++;
        if (pv_cnt != 0 || fs_cnt != 0) begin
            miscompares++;
            $display("FAIL idle_activity: got pixels=%0d frame_starts=%0d, required 0/0", pv_cnt, fs_cnt);
        end
    endtask

    task automatic test_frame();
        int fs0 = fs_cnt;
        int fd0 = fd_cnt;
        int pv0 = pv_cnt;
        capture_en = 1'b1;
        vs(1'b1, 3);
        vs(1'b0, 3);
        vectors++;
        if (busy !== 1'b1 || fs_cnt - fs0 != 1) begin
            miscompares++;
            $display("FAIL frame_begin: got busy=%b starts=%0d, required busy=1 starts=1", busy, fs_cnt - fs0);
        end
        send_line(8, 0, 1'b1, -1, 1'b1);
        send_line(8, 1, 1'b1, -1, 1'b1);
        vs(1'b1, 3);
        vectors++;
        if (fd_cnt - fd0 != 1 || fs_cnt - fs0 != 1 || pv_cnt - pv0 != 8) begin
            miscompares++;
            $display("FAIL frame_counts: got done=%0d start=%0d pixels=%0d, required 1/1/8",
                     fd_cnt - fd0, fs_cnt - fs0, pv_cnt - pv0);
        end
        vectors++;
        if (line_err !== 1'b0 || frame_err !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL frame_clean: got le=%b fe=%b pending=%0d, required 0/0/0", line_err, frame_err, exp_q.size());
        end
    endtask

    task automatic test_long_line();
        vs(1'b0, 3);
        send_line(10, 0, 1'b1, -1, 1'b1);
        vectors++;
        if (line_err !== 1'b1) begin
            miscompares++;
            $display("FAIL long_line_err: got %b, required 1", line_err);
        end
        send_line(8, 1, 1'b1, -1, 1'b1);
        vs(1'b1, 3);
        vectors++;
        if (line_err !== 1'b1 || frame_err !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL long_frame_end: got le=%b fe=%b pending=%0d, required 1/0/0", line_err, frame_err, exp_q.size());
        end
    endtask

    task automatic test_odd_bytes();
        vs(1'b0, 3);
        vectors++;
        if (line_err !== 1'b0) begin
            miscompares++;
            $display("FAIL line_err_clear: got %b, required 0", line_err);
        end
        send_line(7, 0, 1'b1, -1, 1'b1);
        vectors++;
        if (line_err !== 1'b1) begin
            miscompares++;
            $display("FAIL odd_line_err: got %b, required 1", line_err);
        end
        send_line(8, 1, 1'b1, -1, 1'b1);
        vs(1'b1, 3);
        vectors++;
        if (frame_err !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL odd_frame_end: got fe=%b pending=%0d, required 0/0", frame_err, exp_q.size());
        end
    endtask

    task automatic test_three_lines();
        int fd0 = fd_cnt;
        vs(1'b0, 3);
        for (int l = 0; l < 3; l++) send_line(8, l, 1'b1, -1, 1'b1);
        vs(1'b1, 3);
        vectors++;
        if (frame_err !== 1'b1 || line_err !== 1'b0) begin
            miscompares++;
            $display("FAIL three_lines_err: got fe=%b le=%b, required 1/0", frame_err, line_err);
        end
        vectors++;
        if (fd_cnt - fd0 != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL three_lines_done: got done=%0d pending=%0d, required 1/0", fd_cnt - fd0, exp_q.size());
        end
    endtask

    task automatic test_capture_en_drop();
        int fd0 = fd_cnt;
        int pv0 = pv_cnt;
        int fs1;
        vs(1'b0, 3);
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_err_clear: got %b, required 0", frame_err);
        end
        send_line(8, 0, 1'b1, 4, 1'b1);
        send_line(8, 1, 1'b1, -1, 1'b1);
        vs(1'b1, 3);
        vectors++;
        if (fd_cnt - fd0 != 1 || pv_cnt - pv0 != 8 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_en: got done=%0d pixels=%0d busy=%b, required 1/8/0", fd_cnt - fd0, pv_cnt - pv0, busy);
        end
        fs1 = fs_cnt;
        vs(1'b0, 3);
        send_line(8, 0, 1'b0, -1, 1'b1);
        vectors++;
        if (busy !== 1'b0 || fs_cnt != fs1) begin
            miscompares++;
            $display("FAIL stay_idle: got busy=%b starts=%0d, required 0/0", busy, fs_cnt - fs1);
        end
    endtask

    task automatic test_reset_mid_line();
        int fd0;
        capture_en = 1'b1;
        vs(1'b1, 3);
        vs(1'b0, 3);
        send_line(3, 0, 1'b1, -1, 1'b0);
        #40;
        fd0 = fd_cnt;
        vectors++;
        if (pix_data !== 16'hF800 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pre_reset_pixel: got d=%h pending=%0d, required F800/0", pix_data, exp_q.size());
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({pix_valid, pix_data, r_out, g_out, b_out, pix_x, pix_y, frame_start, frame_done,
             line_err, frame_err, busy} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got d=%h busy=%b le=%b fe=%b, required all 0",
                     pix_data, busy, line_err, frame_err);
        end
        #100;
        reset = 1'b1;
        cam_href = 1'b0;
        vs(1'b1, 3);
        vectors++;
        if (fd_cnt != fd0) begin
            miscompares++;
            $display("FAIL reset_no_done: got done=%0d, required 0", fd_cnt - fd0);
        end
        capture_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_long_line();
        test_odd_bytes();
        test_three_lines();
        test_capture_en_drop();
        test_reset_mid_line();
        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Upstream stage of the video path: captures a DVP-style camera stream (PCLK/VSYNC/HREF/D[7:0]) from camGPIO, entirely in the system clock domain.
- Packs byte pairs into RGB565 pixels with x/y coordinates and frame markers.
- Provides RGB888 expansion for the pattern/HDMI stage and the future frame buffer writer.
- Camera pins are oversampled (no camera clock domain); clk must be at least 4x cam_pclk.

Parameters:
- H_ACTIVE, 640, pixels per line (2 bytes per pixel).
- V_ACTIVE, 480, lines per frame.
- X_BITS, 12, width of pix_x.
- Y_BITS, 12, width of pix_y.

Ports:
- clk  input  1  system clock (CLOCK_50_B5B domain), all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- capture_en  input  1  level; enables capture, honoured only at frame boundaries.
- cam_pclk  input  1  camera pixel clock, asynchronous, sampled as data.
- cam_vsync  input  1  camera VSYNC, active high during vertical blank.
- cam_href  input  1  camera HREF, high during active line bytes.
- cam_d  input  8  camera data, valid on cam_pclk rising edge.
- pix_valid  output  1  one-clk strobe, pixel outputs valid.
- pix_data  output  16  RGB565 {first byte, second byte}.
- r_out / g_out / b_out  output  8 each  RGB888 via bit replication: {R5,R5[4:2]}, {G6,G6[5:4]}, {B5,B5[4:2]}.
- pix_x  output  X_BITS  column of the current pixel, 0..H_ACTIVE-1.
- pix_y  output  Y_BITS  line of the current pixel, 0..V_ACTIVE-1.
- frame_start  output  1  one-clk pulse at captured frame start.
- frame_done  output  1  one-clk pulse at captured frame end.
- line_err  output  1  sticky: bad line length or odd byte count this frame.
- frame_err  output  1  sticky: line count != V_ACTIVE this frame.
- busy  output  1  high in S_WAIT_VS and S_CAPTURE.

Behaviour:
- Reset: all outputs 0, state S_IDLE, counters 0, byte phase 0.
- Synchronisation: cam_pclk, cam_vsync, cam_href and cam_d pass through the same 2-flop synchroniser, plus a third flop for edge detection.
  - pclk_rise = s2 & ~s3. vsync_rise and vsync_fall are formed likewise. href_fall = ~s2_href & s3_href.
- Sampling: on a pclk_rise cycle with s2_href high, take s2_d.
  - Phase 0 latches the high byte. Phase 1 forms the pixel.
  - pix_valid asserts on the next clk, i.e. 3 clk after cam_pclk is first sampled high.
- cam_pclk high and low time must each be at least 2 clk periods; operation outside this is undefined.
- States:
  - S_IDLE: busy=0. When capture_en=1, go to S_WAIT_VS.
  - S_WAIT_VS: ignore data. On vsync_fall, go to S_CAPTURE, pulse frame_start, clear line_err, frame_err, x, y and phase.
  - S_CAPTURE, per pixel: emit pix_valid if x<H_ACTIVE and y<V_ACTIVE. Otherwise drop the pixel and set line_err (if x overflows) or frame_err (if y overflows). x increments and saturates at H_ACTIVE.
  - S_CAPTURE, on href_fall: if x!=H_ACTIVE or phase==1, set line_err. Then x=0, phase=0, y increments (saturating at V_ACTIVE).
  - S_CAPTURE, on vsync_rise: if y!=V_ACTIVE, set frame_err. Pulse frame_done. Go to S_WAIT_VS if capture_en=1, else S_IDLE.
- Simultaneous events: if href_fall and pclk_rise occur in the same clk, the byte is processed first, then the line end (pixel completes with the old x).
- A vsync_rise while href is still high is treated as href_fall followed by frame end, both in the same clk.
- capture_en deassert mid-frame: the current frame completes; it takes effect only at vsync_rise.
- Reset mid-frame: immediate return to reset values; no frame_done is emitted.
- Widths: x/y compares are unsigned at X_BITS/Y_BITS. H_ACTIVE must be < 2^X_BITS and V_ACTIVE < 2^Y_BITS.

Decomposition:
- cam_pkg holds the shared constants:
  - state encodings S_IDLE=0, S_WAIT_VS=1, S_CAPTURE=2;
  - RGB565 field positions (R 15:11, G 10:5, B 4:0);
  - synchroniser depth (2).
- Sub-module cam_sync (parameter WIDTH):
  - multi-bit 2-flop synchroniser plus delayed copy;
  - outputs the synced value and the rise/fall vectors;
  - instantiated once over {pclk, vsync, href, d}.

Test Plan (bench uses H_ACTIVE=4, V_ACTIVE=2, clk 50 MHz, pclk 10 MHz):
- Reset held, then released with capture_en=0 and toggling camera -> all outputs 0, busy=0, no pix_valid.
- One frame, bytes 0xF8,0x00 / 0x07,0xE0 / 0x00,0x1F / 0xFF,0xFF per line -> 8 pix_valid; pix_data F800,07E0,001F,FFFF; r/g/b of F800 = FF/00/00; x 0..3, y 0..1; frame_start once, frame_done once, no errors.
- Line with 5 pixels (10 bytes) -> 4 pix_valid only, line_err=1 through frame end; cleared at the next vsync_fall.
- Line with 7 bytes -> line_err=1 at href_fall; next line x restarts at 0 with phase 0.
- Frame with 3 lines -> third line produces no pix_valid; frame_err=1 at vsync_rise; frame_done still pulses.
- capture_en dropped mid-line -> remaining pixels of that frame still captured, frame_done pulses, state S_IDLE, busy=0; async reset asserted mid-line -> outputs 0 within the same clk, no frame_done.
